// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// One-cycle latency; hold freezes the register, hazard_stall asks upstream to hold PC and IF/ID.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ALUSrc,
    input  logic        RegDst,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        Beq,
    input  logic        Bne,
    input  logic        Jump,
    input  logic        MemToReg,
    input  logic        RegWrite,
    input  logic [2:0]  ALUControl,
    input  logic [31:0] id_pc4,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_valid,
    input  logic        flush,
    input  logic        hold,
    output logic        ex_ALUSrc,
    output logic        ex_RegDst,
    output logic        ex_MemWrite,
    output logic        ex_MemRead,
    output logic        ex_Beq,
    output logic        ex_Bne,
    output logic        ex_Jump,
    output logic        ex_MemToReg,
    output logic        ex_RegWrite,
    output logic [2:0]  ex_ALUControl,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic        ex_valid,
    output logic        hazard_stall,
    output logic [15:0] bubble_count
);

    typedef struct packed {
        logic       alusrc;
        logic       regdst;
        logic       memwrite;
        logic       memread;
        logic       beq;
        logic       bne;
        logic       jump;
        logic       memtoreg;
        logic       regwrite;
        logic [2:0] aluctl;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } dat_t;

    ctrl_t       id_ctrl;
    dat_t        id_dat;
    ctrl_t       ctrl_q;
    dat_t        dat_q;
    logic        valid_q;
    logic [15:0] bubble_q;
    logic        load_use;

    assign id_ctrl = {ALUSrc, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite, ALUControl};
    assign id_dat  = {id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd};

    // r0 never carries a loaded value, so a load targeting it cannot create a dependency.
    assign load_use = valid_q & ctrl_q.memread & (dat_q.rt != 5'd0) & id_valid
                    & ((dat_q.rt == id_rs) | (dat_q.rt == id_rt));

    // A frozen or killed EX slot will not advance next cycle, so stalling would be meaningless.
    assign hazard_stall = load_use & ~hold & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            dat_q    <= '0;
            valid_q  <= 1'b0;
            bubble_q <= '0;
        end else if (flush) begin
            ctrl_q  <= '0;
            dat_q   <= '0;
            valid_q <= 1'b0;
        end else if (!hold) begin
            if (hazard_stall) begin
                ctrl_q   <= '0;
                dat_q    <= '0;
                valid_q  <= 1'b0;
                bubble_q <= (bubble_q == 16'hFFFF) ? bubble_q : bubble_q + 16'd1;
            end else begin
                ctrl_q  <= id_valid ? id_ctrl : '0;
                dat_q   <= id_dat;
                valid_q <= id_valid;
            end
        end
    end

    // Side-effecting controls are qualified by valid so a dead slot can never commit.
    assign ex_MemWrite   = ctrl_q.memwrite & valid_q;
    assign ex_MemRead    = ctrl_q.memread  & valid_q;
    assign ex_Beq        = ctrl_q.beq      & valid_q;
    assign ex_Bne        = ctrl_q.bne      & valid_q;
    assign ex_Jump       = ctrl_q.jump     & valid_q;
    assign ex_RegWrite   = ctrl_q.regwrite & valid_q;
    assign ex_ALUSrc     = ctrl_q.alusrc;
    assign ex_RegDst     = ctrl_q.regdst;
    assign ex_MemToReg   = ctrl_q.memtoreg;
    assign ex_ALUControl = ctrl_q.aluctl;
    assign ex_pc4        = dat_q.pc4;
    assign ex_rs_data    = dat_q.rs_data;
    assign ex_rt_data    = dat_q.rt_data;
    assign ex_imm        = dat_q.imm;
    assign ex_rs         = dat_q.rs;
    assign ex_rt         = dat_q.rt;
    assign ex_rd         = dat_q.rd;
    assign ex_valid      = valid_q;
    assign bubble_count  = bubble_q;

endmodule
